// File: rtl/arch_map_mw_pkg.sv
// Shared definitions for the multi-retire architectural map: default sizes,
// the committed tag record and the recovery FSM state encoding.
package arch_map_mw_pkg;

  localparam int DEF_N_ARCH       = 32;
  localparam int DEF_N_PHYS       = 64;
  localparam int DEF_RETIRE_WIDTH = 2;
  localparam int DEF_READ_PORTS   = 2;

  // Tag width is fixed here so every block agrees on the record layout.
  localparam int PR_W = $clog2(DEF_N_PHYS);

  typedef struct packed {
    logic [PR_W-1:0] phys_reg;
    logic            ready;
  } tag_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } arch_map_state_e;

  // Identity mapping used at reset: arch reg i lives in physical reg i,
  // and its committed value is by definition ready.
  function automatic tag_t reset_tag(input int unsigned idx);
    tag_t t;
    t.phys_reg = PR_W'(idx);
    t.ready    = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/arch_map_mw_if.sv
// Retire / lookup / recovery bundle between the core (master) and the
// architectural map (slave).
//
// Handshake: recover_req is a one-cycle flush pulse honoured only when the
// map is idle; the map then raises recover_valid and holds recover_map
// stable until it samples recover_ack high, after which recover_valid drops
// on the following cycle. recover_ack while recover_valid is low is ignored.
import arch_map_mw_pkg::*;

interface arch_map_mw_if #(
  parameter int N_ARCH       = DEF_N_ARCH,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH,
  parameter int READ_PORTS   = DEF_READ_PORTS
);
  localparam int AR_W = $clog2(N_ARCH);

  logic [RETIRE_WIDTH-1:0]           retire_en;
  logic [RETIRE_WIDTH-1:0][AR_W-1:0] retire_ar;
  tag_t [RETIRE_WIDTH-1:0]           retire_t;
  logic [RETIRE_WIDTH-1:0]           free_valid;
  tag_t [RETIRE_WIDTH-1:0]           free_t;
  logic [READ_PORTS-1:0][AR_W-1:0]   read_idx;
  tag_t [READ_PORTS-1:0]             read_out;
  logic                              recover_req;
  logic                              recover_ack;
  logic                              recover_valid;
  tag_t [N_ARCH-1:0]                 recover_map;
  logic                              busy;

  modport master (
    output retire_en, retire_ar, retire_t, read_idx, recover_req, recover_ack,
    input  free_valid, free_t, read_out, recover_valid, recover_map, busy
  );

  modport slave (
    input  retire_en, retire_ar, retire_t, read_idx, recover_req, recover_ack,
    output free_valid, free_t, read_out, recover_valid, recover_map, busy
  );

endinterface

// File: rtl/arch_map_mw_retire_merge.sv
// Resolves one retire group against the current committed map. Slot 0 is
// the oldest: each slot's displaced tag is the tag left by the youngest
// older slot writing the same arch reg (or the map entry if none), and only
// the youngest slot targeting a given arch reg actually writes it.
import arch_map_mw_pkg::*;

module arch_map_mw_retire_merge #(
  parameter int N_ARCH       = DEF_N_ARCH,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH,
  parameter int AR_W         = $clog2(N_ARCH)
) (
  input  logic [RETIRE_WIDTH-1:0]           en_i,
  input  logic [RETIRE_WIDTH-1:0][AR_W-1:0] ar_i,
  input  tag_t [RETIRE_WIDTH-1:0]           tag_i,
  input  tag_t [N_ARCH-1:0]                 map_i,
  output tag_t [RETIRE_WIDTH-1:0]           old_tag_o,
  output logic [RETIRE_WIDTH-1:0]           wr_o
);

  // Per-slot displaced tag and write ownership, scanned in slot order.
  always_comb begin
    old_tag_o = '0;
    wr_o      = '0;
    for (int s = 0; s < RETIRE_WIDTH; s++) begin
      old_tag_o[s] = map_i[ar_i[s]];
      for (int j = 0; j < s; j++) begin
        if (en_i[j] && (ar_i[j] == ar_i[s])) old_tag_o[s] = tag_i[j];
      end
      wr_o[s] = en_i[s];
      for (int k = s + 1; k < RETIRE_WIDTH; k++) begin
        if (en_i[k] && (ar_i[k] == ar_i[s])) wr_o[s] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/arch_map_mw.sv
// Committed architectural map for the R10K core. Applies up to RETIRE_WIDTH
// retirements per cycle, returns displaced tags to the free list one cycle
// later, serves combinational lookups from the pre-retire state, and hands
// a frozen copy of the map to the rename map table on a flush.
// Optional build macro: ARCH_MAP_ZERO_REG_EN hardwires arch reg 0 to tag 0.
import arch_map_mw_pkg::*;

module arch_map_mw #(
  parameter int N_ARCH       = DEF_N_ARCH,
  parameter int RETIRE_WIDTH = DEF_RETIRE_WIDTH,
  parameter int READ_PORTS   = DEF_READ_PORTS
) (
  input  logic            clock,
  input  logic            reset,
  arch_map_mw_if.slave    bus,
  output arch_map_state_e state_o
);

  arch_map_state_e         state_q;
  logic                    recover_valid_q;
  logic                    busy_q;
  tag_t [N_ARCH-1:0]       map_q, map_d;
  logic [RETIRE_WIDTH-1:0] slot_en;
  logic [RETIRE_WIDTH-1:0] slot_wr;
  tag_t [RETIRE_WIDTH-1:0] old_t;
  logic [RETIRE_WIDTH-1:0] free_valid_q;
  tag_t [RETIRE_WIDTH-1:0] free_t_q;

  // Retires are honoured only while idle; writes to arch reg 0 are dropped
  // when it is hardwired.
  always_comb begin
    slot_en = '0;
    for (int s = 0; s < RETIRE_WIDTH; s++) begin
`ifdef ARCH_MAP_ZERO_REG_EN
      slot_en[s] = bus.retire_en[s] && (state_q == IDLE) && (bus.retire_ar[s] != '0);
`else
      slot_en[s] = bus.retire_en[s] && (state_q == IDLE);
`endif
    end
  end

  arch_map_mw_retire_merge #(
    .N_ARCH       (N_ARCH),
    .RETIRE_WIDTH (RETIRE_WIDTH)
  ) u_merge (
    .en_i      (slot_en),
    .ar_i      (bus.retire_ar),
    .tag_i     (bus.retire_t),
    .map_i     (map_q),
    .old_tag_o (old_t),
    .wr_o      (slot_wr)
  );

  // Next map: apply the surviving (youngest) write for each arch reg.
  always_comb begin
    map_d = map_q;
    for (int s = 0; s < RETIRE_WIDTH; s++) begin
      if (slot_wr[s]) map_d[bus.retire_ar[s]] = bus.retire_t[s];
    end
  end

  // Committed map storage; reset restores the identity mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ARCH; i++) map_q[i] <= reset_tag(i);
    end else begin
      map_q <= map_d;
    end
  end

  // Free-list return path, one cycle behind the retire that displaced it.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_valid_q <= '0;
      free_t_q     <= '0;
    end else begin
      free_valid_q <= slot_en;
      for (int s = 0; s < RETIRE_WIDTH; s++) begin
        free_t_q[s] <= slot_en[s] ? old_t[s] : '0;
      end
    end
  end

  // Recovery FSM with registered snapshot-valid and busy flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      recover_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.recover_req) begin
            state_q         <= RECOVER;
            recover_valid_q <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        RECOVER: begin
          if (bus.recover_ack) begin
            state_q         <= IDLE;
            recover_valid_q <= 1'b0;
            busy_q          <= 1'b0;
          end
        end
        default: begin
          state_q         <= IDLE;
          recover_valid_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  // Lookups and the snapshot come straight from the registered map, so the
  // snapshot is stable for as long as writes are blocked in RECOVER.
  always_comb begin
    bus.read_out    = '0;
    bus.recover_map = map_q;
    for (int p = 0; p < READ_PORTS; p++) begin
      bus.read_out[p] = map_q[bus.read_idx[p]];
`ifdef ARCH_MAP_ZERO_REG_EN
      if (bus.read_idx[p] == '0) bus.read_out[p] = '0;
`endif
    end
`ifdef ARCH_MAP_ZERO_REG_EN
    bus.recover_map[0] = '0;
`endif
  end

  assign bus.free_valid    = free_valid_q;
  assign bus.free_t        = free_t_q;
  assign bus.recover_valid = recover_valid_q;
  assign bus.busy          = busy_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_arch_map_mw.sv
// Directed bench for arch_map_mw: reset identity, single and grouped
// retires, same-register collisions, recovery hold/ack, reset during
// recovery and the arch-reg-0 build option.
module tb_arch_map_mw;
  import arch_map_mw_pkg::*;

  localparam int AR_W = $clog2(DEF_N_ARCH);

  logic            clock = 1'b0;
  logic            reset;
  arch_map_state_e state_o;
  int              checks   = 0;
  int              failures = 0;

  arch_map_mw_if amif ();

  arch_map_mw dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (amif.slave),
    .state_o (state_o)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    amif.retire_en   = '0;
    amif.retire_ar   = '0;
    amif.retire_t    = '0;
    amif.read_idx    = '0;
    amif.recover_req = 1'b0;
    amif.recover_ack = 1'b0;
  endtask

  function automatic tag_t mk(input int p);
    tag_t t;
    t.phys_reg = PR_W'(p);
    t.ready    = 1'b1;
    return t;
  endfunction

  task automatic set_slot(input int s, input int ar, input int p);
    amif.retire_en[s] = 1'b1;
    amif.retire_ar[s] = AR_W'(ar);
    amif.retire_t[s]  = mk(p);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_read(input string tag, input int idx, input int exp);
    amif.read_idx[1] = AR_W'(idx);
    #1;
    check(tag, 32'(amif.read_out[1].phys_reg), 32'(exp));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_free_valid", 32'(amif.free_valid), 32'd0);
    check("rst_recover_valid", 32'(amif.recover_valid), 32'd0);
    check("rst_busy", 32'(amif.busy), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    reset = 1'b0;
    for (int i = 0; i < DEF_N_ARCH / 2; i++) begin
      amif.read_idx[0] = AR_W'(2 * i);
      amif.read_idx[1] = AR_W'(2 * i + 1);
      #1;
      check("rst_identity_p0", 32'(amif.read_out[0].phys_reg), 32'(2 * i));
      check("rst_identity_p1", 32'(amif.read_out[1].phys_reg), 32'(2 * i + 1));
    end
    tick();

    // Single retire on slot 0: ar3 -> T33
    set_slot(0, 3, 33);
    check_read("no_bypass_ar3", 3, 3);
    tick();
    idle_inputs();
    check("a_free_valid", 32'(amif.free_valid), 32'd1);
    check("a_free_t0", 32'(amif.free_t[0].phys_reg), 32'd3);
    check_read("a_read_ar3", 3, 33);
    tick();
    check("a_free_valid_clear", 32'(amif.free_valid), 32'd0);

    // Collision: slot0 ar7 -> T40, slot1 ar7 -> T41
    set_slot(0, 7, 40);
    set_slot(1, 7, 41);
    tick();
    idle_inputs();
    check("b_free_valid", 32'(amif.free_valid), 32'd3);
    check("b_free_t0", 32'(amif.free_t[0].phys_reg), 32'd7);
    check("b_free_t1", 32'(amif.free_t[1].phys_reg), 32'd40);
    check_read("b_read_ar7", 7, 41);

    // Independent slots: ar10 -> T20, ar11 -> T21
    set_slot(0, 10, 20);
    set_slot(1, 11, 21);
    tick();
    idle_inputs();
    check("b2_free_t0", 32'(amif.free_t[0].phys_reg), 32'd10);
    check("b2_free_t1", 32'(amif.free_t[1].phys_reg), 32'd11);
    check_read("b2_read_ar10", 10, 20);
    check_read("b2_read_ar11", 11, 21);

    // Slot 1 only: ar3 -> T34 displaces T33
    set_slot(1, 3, 34);
    tick();
    idle_inputs();
    check("b3_free_valid", 32'(amif.free_valid), 32'd2);
    check("b3_free_t1", 32'(amif.free_t[1].phys_reg), 32'd33);

    // Retire ar2 -> T50 together with a flush request
    set_slot(0, 2, 50);
    amif.recover_req = 1'b1;
    tick();
    idle_inputs();
    check("c_recover_valid", 32'(amif.recover_valid), 32'd1);
    check("c_busy", 32'(amif.busy), 32'd1);
    check("c_state", 32'(state_o), 32'(RECOVER));
    check("c_map2", 32'(amif.recover_map[2].phys_reg), 32'd50);
    check("c_map7", 32'(amif.recover_map[7].phys_reg), 32'd41);
    check("c_map3", 32'(amif.recover_map[3].phys_reg), 32'd34);
    check("c_free_valid", 32'(amif.free_valid), 32'd1);
    check("c_free_t0", 32'(amif.free_t[0].phys_reg), 32'd2);

    // Hold without ack while retires and requests keep arriving
    for (int k = 0; k < 3; k++) begin
      set_slot(0, 4, 60);
      amif.recover_req = 1'b1;
      tick();
      idle_inputs();
      check("c_hold_free_valid", 32'(amif.free_valid), 32'd0);
      check("c_hold_recover_valid", 32'(amif.recover_valid), 32'd1);
      check("c_hold_map4", 32'(amif.recover_map[4].phys_reg), 32'd4);
      check("c_hold_map2", 32'(amif.recover_map[2].phys_reg), 32'd50);
      check("c_hold_state", 32'(state_o), 32'(RECOVER));
    end
    amif.recover_ack = 1'b1;
    tick();
    idle_inputs();
    check("c_exit_state", 32'(state_o), 32'(IDLE));
    check("c_exit_recover_valid", 32'(amif.recover_valid), 32'd0);
    check("c_exit_busy", 32'(amif.busy), 32'd0);
    check_read("c_exit_read_ar4", 4, 4);

    // Ack while idle has no effect
    amif.recover_ack = 1'b1;
    tick();
    idle_inputs();
    check("d_idle_ack_state", 32'(state_o), 32'(IDLE));
    check("d_idle_ack_valid", 32'(amif.recover_valid), 32'd0);

    // Retires resume after recovery
    set_slot(0, 4, 60);
    tick();
    idle_inputs();
    check("d_free_valid", 32'(amif.free_valid), 32'd1);
    check("d_free_t0", 32'(amif.free_t[0].phys_reg), 32'd4);
    check_read("d_read_ar4", 4, 60);

    // Reset while in RECOVER
    amif.recover_req = 1'b1;
    tick();
    idle_inputs();
    check("e_state", 32'(state_o), 32'(RECOVER));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("e_state_after_rst", 32'(state_o), 32'(IDLE));
    check("e_recover_valid", 32'(amif.recover_valid), 32'd0);
    check("e_busy", 32'(amif.busy), 32'd0);
    check("e_free_valid", 32'(amif.free_valid), 32'd0);
    check_read("e_read_ar2", 2, 2);
    check_read("e_read_ar7", 7, 7);
    check_read("e_read_ar4", 4, 4);

    // Arch reg 0 behaviour: slot0 ar0 -> T45, slot1 ar9 -> T55
    set_slot(0, 0, 45);
    set_slot(1, 9, 55);
    tick();
    idle_inputs();
    check("f_free_t1", 32'(amif.free_t[1].phys_reg), 32'd9);
    check_read("f_read_ar9", 9, 55);
`ifdef ARCH_MAP_ZERO_REG_EN
    check("f_free_valid", 32'(amif.free_valid), 32'd2);
    check_read("f_read_ar0", 0, 0);
    check("f_recover_map0", 32'(amif.recover_map[0].phys_reg), 32'd0);
`else
    check("f_free_valid", 32'(amif.free_valid), 32'd3);
    check("f_free_t0", 32'(amif.free_t[0].phys_reg), 32'd0);
    check_read("f_read_ar0", 0, 45);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
